// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display paths: hex glyph table,
// all-off constants and the digit index type.
package seg_pkg;

  localparam int DIGIT_W = 2;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [3:0] anode_for(input digit_t d);
    return ~(4'b0001 << d);
  endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan16.sv
// Four-digit multiplexed hex display driver with frame-synchronous value
// swap, anode blanking at the start of each slot and leading-zero blanking.
module seg_scan16
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] val_i,
  input  logic        upd_i,
  input  logic        blank_lz_i,
  input  logic [3:0]  dp_i,
  input  logic        en_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [1:0]  digit_o,
  output logic        frame_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  digit_t           digit;
  digit_t           digit_nxt;
  logic [15:0]      shadow;
  logic [15:0]      active;
  logic [15:0]      active_nxt;
  logic             pend;
  logic             frame_edge;
  logic             commit;
  logic [3:0]       nib;
  logic [6:0]       seg_dec;
  logic             lz_blank;
  logic             slot_blank;

  // Outputs are derived from the post-edge scan state so that anodes,
  // segments and digit index always describe the same slot.
  always_comb begin
    cnt_nxt    = cnt;
    digit_nxt  = digit;
    frame_edge = 1'b0;
    if (en_i) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt    = '0;
        digit_nxt  = digit + 1'b1;
        frame_edge = (digit == 2'd3);
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end

    commit     = frame_edge && pend;
    active_nxt = commit ? shadow : active;
    nib        = active_nxt[{digit_nxt, 2'b00} +: 4];

    lz_blank   = blank_lz_i && (digit_nxt != '0) &&
                 ((active_nxt >> {digit_nxt, 2'b00}) == '0);
    slot_blank = (int'(cnt_nxt) < BLANK_CYC) || lz_blank;
  end

  hex7seg_dec u_dec (
    .nibble (nib),
    .seg    (seg_dec)
  );

  // Capture keeps running while the scan is frozen; the last request
  // before a frame boundary is the one that gets committed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt     <= '0;
      digit   <= '0;
      shadow  <= '0;
      active  <= '0;
      pend    <= 1'b0;
      an_o    <= AN_OFF;
      seg_o   <= SEG_OFF;
      dp_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      if (upd_i) begin
        shadow <= val_i;
        pend   <= 1'b1;
      end else if (commit) begin
        pend   <= 1'b0;
      end

      frame_o <= frame_edge;

      if (en_i) begin
        cnt    <= cnt_nxt;
        digit  <= digit_nxt;
        active <= active_nxt;
        if (slot_blank) begin
          an_o  <= AN_OFF;
          seg_o <= SEG_OFF;
          dp_o  <= 1'b1;
        end else begin
          an_o  <= anode_for(digit_nxt);
          seg_o <= seg_dec;
          dp_o  <= ~dp_i[digit_nxt];
        end
      end
    end
  end

  assign digit_o = digit;

endmodule

// File: tb/tb_seg_scan16.sv
// Self-checking bench for seg_scan16: random traffic against a frame-position
// model, a table of spot checks, and hand-written multi-cycle corner cases.
module tb_seg_scan16;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * RD;

  localparam logic [6:0] SEG_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [15:0] val;
    bit          blz;
    logic [3:0]  dp;
    int          digit;
    int          cnt;
    logic [3:0]  an;
    logic [6:0]  seg;
    bit          dpo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] val;
  logic        upd;
  logic        blz;
  logic [3:0]  dp_in;
  logic        en;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [1:0]  digit_o;
  logic        frame_o;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: position within the frame plus the value buffers.
  int          m_pos;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  bit          m_pend;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [1:0]  e_dig;
  logic        e_frame;

  vec_t tbl[$];

  seg_scan16 #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .val_i      (val),
    .upd_i      (upd),
    .blank_lz_i (blz),
    .dp_i       (dp_in),
    .en_i       (en),
    .an_o       (an_o),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .digit_o    (digit_o),
    .frame_o    (frame_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    m_pos    = 0;
    m_active = '0;
    m_shadow = '0;
    m_pend   = 0;
    e_an     = 4'hF;
    e_seg    = 7'h7F;
    e_dp     = 1'b1;
    e_dig    = 2'd0;
    e_frame  = 1'b0;
  endtask

  task automatic model_outputs();
    int  c;
    int  d;
    bit  blank;
    logic [3:0] n;
    c     = m_pos % RD;
    d     = m_pos / RD;
    blank = (c < BC) || (blz && d != 0 && (m_active >> (4 * d)) == 16'h0);
    e_dig = 2'(d);
    if (blank) begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      n        = 4'((m_active >> (4 * d)) & 16'hF);
      e_an     = 4'hF;
      e_an[d]  = 1'b0;
      e_seg    = SEG_REF[n];
      e_dp     = ~dp_in[d];
    end
  endtask

  task automatic model_edge(input bit u, input logic [15:0] v);
    bit wrap;
    if (en) begin
      wrap = (m_pos == FRAME - 1);
      if (wrap && m_pend) begin
        m_active = m_shadow;
        m_pend   = 0;
      end
      m_pos = (m_pos + 1) % FRAME;
      model_outputs();
      e_frame = wrap;
    end else begin
      e_frame = 1'b0;
    end
    if (u) begin
      m_shadow = v;
      m_pend   = 1;
    end
  endtask

  task automatic checkOutput(input string name);
    vectors++;
    if ({an_o, seg_o, dp_o, digit_o, frame_o} !== {e_an, e_seg, e_dp, e_dig, e_frame}) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t: an=%h seg=%h dp=%b digit=%0d frame=%b, expected an=%h seg=%h dp=%b digit=%0d frame=%b",
               name, $time, an_o, seg_o, dp_o, digit_o, frame_o,
               e_an, e_seg, e_dp, e_dig, e_frame);
    end
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit u, input logic [15:0] v);
    upd = u;
    val = v;
    @(posedge clk);
    model_edge(u, v);
    #1;
    upd = 1'b0;
    checkOutput("cycle");
  endtask

  task automatic goto_pos(input int target);
    int n;
    n = 0;
    while (m_pos != target && n < 2 * FRAME) begin
      applyStimulus(1'b0, 16'h0);
      n++;
    end
    if (m_pos != target) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL goto: position %0d not reached, at %0d", target, m_pos);
    end
  endtask

  task automatic load_value(input logic [15:0] v);
    int n;
    applyStimulus(1'b1, v);
    n = 0;
    while ((m_active != v || m_pend) && n < 3 * FRAME) begin
      applyStimulus(1'b0, 16'h0);
      n++;
    end
    if (m_active != v) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL load: value %h never became active", v);
    end
  endtask

  initial begin
    int frames_seen;
    logic [15:0] mask;

    rst = 1'b0; upd = 1'b0; val = '0; blz = 1'b0; dp_in = '0; en = 1'b1;
    model_reset();
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_init");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Spot-check table: value, blanking mode, dp, slot position, expected pins.
    tbl.push_back('{16'h12AF, 1'b0, 4'h0, 0, 2, 4'hE, 7'h0E, 1'b1});
    tbl.push_back('{16'h12AF, 1'b0, 4'h0, 0, 7, 4'hE, 7'h0E, 1'b1});
    tbl.push_back('{16'h12AF, 1'b0, 4'h0, 1, 0, 4'hF, 7'h7F, 1'b1});
    tbl.push_back('{16'h12AF, 1'b0, 4'h0, 1, 4, 4'hD, 7'h08, 1'b1});
    tbl.push_back('{16'h12AF, 1'b0, 4'h0, 2, 1, 4'hF, 7'h7F, 1'b1});
    tbl.push_back('{16'h12AF, 1'b0, 4'h0, 2, 5, 4'hB, 7'h24, 1'b1});
    tbl.push_back('{16'h12AF, 1'b0, 4'h0, 3, 2, 4'h7, 7'h79, 1'b1});
    tbl.push_back('{16'h12AF, 1'b0, 4'h0, 3, 7, 4'h7, 7'h79, 1'b1});
    tbl.push_back('{16'h0030, 1'b1, 4'h0, 3, 4, 4'hF, 7'h7F, 1'b1});
    tbl.push_back('{16'h0030, 1'b1, 4'h0, 2, 4, 4'hF, 7'h7F, 1'b1});
    tbl.push_back('{16'h0030, 1'b1, 4'h0, 1, 4, 4'hD, 7'h30, 1'b1});
    tbl.push_back('{16'h0030, 1'b1, 4'h0, 0, 4, 4'hE, 7'h40, 1'b1});
    tbl.push_back('{16'h0000, 1'b1, 4'h0, 0, 4, 4'hE, 7'h40, 1'b1});
    tbl.push_back('{16'h0000, 1'b1, 4'h0, 1, 4, 4'hF, 7'h7F, 1'b1});
    tbl.push_back('{16'h0000, 1'b1, 4'h0, 3, 4, 4'hF, 7'h7F, 1'b1});
    tbl.push_back('{16'h12AF, 1'b0, 4'b0100, 2, 3, 4'hB, 7'h24, 1'b0});
    tbl.push_back('{16'h12AF, 1'b0, 4'b0100, 1, 3, 4'hD, 7'h08, 1'b1});
    tbl.push_back('{16'h12AF, 1'b0, 4'b0100, 2, 1, 4'hF, 7'h7F, 1'b1});

    foreach (tbl[i]) begin
      blz   = tbl[i].blz;
      dp_in = tbl[i].dp;
      if (m_active != tbl[i].val || m_pend) load_value(tbl[i].val);
      goto_pos(tbl[i].digit * RD + tbl[i].cnt);
      checkField($sformatf("tbl%0d_an", i), 32'(an_o), 32'(tbl[i].an));
      checkField($sformatf("tbl%0d_seg", i), 32'(seg_o), 32'(tbl[i].seg));
      checkField($sformatf("tbl%0d_dp", i), 32'(dp_o), 32'(tbl[i].dpo));
    end

    // Mid-frame update must not tear the frame being shown.
    blz = 1'b0; dp_in = 4'h0;
    load_value(16'h5555);
    goto_pos(2 * RD + 3);
    applyStimulus(1'b1, 16'hAAAA);
    goto_pos(3 * RD + 4);
    checkField("tear_d3_old", 32'(seg_o), 32'h12);
    goto_pos(0 * RD + 4);
    checkField("tear_d0_new", 32'(seg_o), 32'h08);
    goto_pos(3 * RD + 4);
    checkField("tear_d3_new", 32'(seg_o), 32'h08);

    // Update landing exactly on the wrap edge while another is pending.
    goto_pos(1 * RD + 3);
    applyStimulus(1'b1, 16'h0002);
    goto_pos(FRAME - 1);
    applyStimulus(1'b1, 16'h0001);
    checkField("collide_frame", 32'(frame_o), 32'h1);
    goto_pos(4);
    checkField("collide_first", 32'(seg_o), 32'h24);
    goto_pos(RD + 4);
    goto_pos(4);
    checkField("collide_second", 32'(seg_o), 32'h79);

    // Freeze across a would-be frame boundary, with capture still active.
    goto_pos(FRAME - 2);
    en = 1'b0;
    frames_seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) dp_in = 4'hF;
      applyStimulus(k == 10, 16'h3C3C);
      if (frame_o) frames_seen++;
    end
    checkField("freeze_frames", 32'(frames_seen), 32'h0);
    en = 1'b1;
    dp_in = 4'b0100;
    for (int k = 0; k < 2 * FRAME; k++) applyStimulus(1'b0, 16'h0);

    // Random traffic checked cycle-by-cycle against the model.
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(9) != 0);
      if ($urandom_range(15) == 0) blz = ~blz;
      if ($urandom_range(7) == 0) dp_in = 4'($urandom);
      case ($urandom_range(3))
        0: mask = 16'hFFFF;
        1: mask = 16'h00FF;
        2: mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      applyStimulus($urandom_range(7) == 0, 16'($urandom) & mask);
    end
    en = 1'b1;

    // Asynchronous reset in the middle of a clock period.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checkOutput("reset_async");
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_held");
    rst = 1'b0;
    for (int k = 0; k < FRAME + 4; k++) applyStimulus(1'b0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
